// File: rtl/vx_axi_mem_responder_if.sv
// AXI4 bus bundle between the Vortex master port and the on-chip memory responder.
// Only the channel signals the responder acts on are carried.
interface vx_axi_mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8
) ();
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/vx_axi_mem_responder.sv
// AXI4 slave terminating the Vortex master port in a word-addressed on-chip memory.
// Independent read/write FSMs, one outstanding INCR burst per path.
module vx_axi_mem_responder #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEPTH      = 1024
) (
  input logic                   clk,
  input logic                   rstn,
  vx_axi_mem_responder_if.slave s_axi
);
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned SZ = $clog2(NB);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ID_WIDTH-1:0]   w_id, r_id;
  logic [IW-1:0]         w_idx, r_idx, r_idx_nxt, ar_idx;
  logic [7:0]            w_len, w_cnt, r_len, r_cnt;
  logic                  w_err, r_err;
  logic [DATA_WIDTH-1:0] r_data;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_bad, ar_bad, w_last_beat, r_last_beat;
  logic unused_addr_bits;

  // Only the word-index slice of the addresses is meaningful.
  assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid  && s_axi.wready;
  assign b_hs  = s_axi.bvalid  && s_axi.bready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs  = s_axi.rvalid  && s_axi.rready;

  assign aw_bad      = (s_axi.awburst != 2'b01) || (s_axi.awsize != 3'(SZ));
  assign ar_bad      = (s_axi.arburst != 2'b01) || (s_axi.arsize != 3'(SZ));
  assign ar_idx      = s_axi.araddr[SZ +: IW];
  assign r_idx_nxt   = r_idx + IW'(1);
  assign w_last_beat = s_axi.wlast || (w_cnt == w_len);
  assign r_last_beat = (r_cnt == r_len);

  assign s_axi.bid   = w_id;
  assign s_axi.bresp = {w_err, 1'b0};
  assign s_axi.rid   = r_id;
  assign s_axi.rresp = {r_err, 1'b0};
  assign s_axi.rdata = r_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Idle readies are qualified by rstn so they stay low while reset is held.
  always_comb begin
    w_state_nxt   = w_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi.awready = rstn;
        if (aw_hs) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (b_hs) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt   = r_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    s_axi.rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi.arready = rstn;
        if (ar_hs) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        s_axi.rlast  = r_last_beat;
        if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_id  <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_id  <= s_axi.awid;
      w_idx <= s_axi.awaddr[SZ +: IW];
      w_len <= s_axi.awlen;
      w_cnt <= '0;
      w_err <= aw_bad;
    end else if (w_hs) begin
      w_idx <= w_idx + IW'(1);
      w_cnt <= w_cnt + 8'd1;
      if (s_axi.wlast != (w_cnt == w_len)) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_err) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  // Next beat is fetched on the accepting edge, so a same-cycle write to that index is not seen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_id   <= '0;
      r_idx  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else if (ar_hs) begin
      r_id   <= s_axi.arid;
      r_idx  <= ar_idx;
      r_len  <= s_axi.arlen;
      r_cnt  <= '0;
      r_err  <= ar_bad;
      r_data <= ar_bad ? '0 : mem[ar_idx];
    end else if (r_hs && !r_last_beat) begin
      r_idx  <= r_idx_nxt;
      r_cnt  <= r_cnt + 8'd1;
      r_data <= r_err ? '0 : mem[r_idx_nxt];
    end
  end
endmodule

// File: tb/tb_vx_axi_mem_responder.sv
// Directed bench for vx_axi_mem_responder: 64-bit data (NB=8, SZ=3), 64-word memory.
module tb_vx_axi_mem_responder;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rstn;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [DW-1:0] wbuf [256];
  logic [7:0]    sbuf [256];
  logic [DW-1:0] rexp [256];

  vx_axi_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .ID_WIDTH(8)) m ();

  vx_axi_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(32), .ID_WIDTH(8), .DEPTH(64)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .s_axi(m)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int unsigned nbeats, input bit stall,
                          input logic [1:0] exp_resp, input string tag);
    int unsigned t;
    m.awid = id; m.awaddr = addr; m.awlen = len; m.awsize = 3'd3; m.awburst = burst;
    m.awvalid = 1'b1;
    t = 0;
    while (!m.awready && t < 100) begin tick(); t++; end
    chk({tag, "_awready"}, m.awready, 1);
    tick();
    m.awvalid = 1'b0;
    chk({tag, "_wready_t1"}, m.wready, 1);
    for (int unsigned i = 0; i < nbeats; i++) begin
      if (stall) begin
        while ($urandom_range(0, 2) == 0) begin m.wvalid = 1'b0; tick(); end
      end
      m.wvalid = 1'b1; m.wdata = wbuf[i]; m.wstrb = sbuf[i]; m.wlast = (i == nbeats - 1);
      t = 0;
      while (!m.wready && t < 100) begin tick(); t++; end
      chk({tag, "_wready"}, m.wready, 1);
      tick();
    end
    m.wvalid = 1'b0; m.wlast = 1'b0;
    chk({tag, "_bvalid_t1"}, m.bvalid, 1);
    chk({tag, "_bid"}, m.bid, id);
    chk({tag, "_bresp"}, m.bresp, exp_resp);
    if (stall) begin
      tick();
      chk({tag, "_bhold_valid"}, m.bvalid, 1);
      chk({tag, "_bhold_resp"}, m.bresp, exp_resp);
    end
    m.bready = 1'b1;
    tick();
    m.bready = 1'b0;
    chk({tag, "_bvalid_drop"}, m.bvalid, 0);
    chk({tag, "_awready_back"}, m.awready, 1);
  endtask

  task automatic rd_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input bit stall, input logic [1:0] exp_resp,
                          input string tag);
    int unsigned t;
    m.arid = id; m.araddr = addr; m.arlen = len; m.arsize = size; m.arburst = 2'b01;
    m.arvalid = 1'b1;
    t = 0;
    while (!m.arready && t < 100) begin tick(); t++; end
    chk({tag, "_arready"}, m.arready, 1);
    tick();
    m.arvalid = 1'b0;
    chk({tag, "_rvalid_t1"}, m.rvalid, 1);
    for (int unsigned i = 0; i <= len; i++) begin
      if (stall) begin
        while ($urandom_range(0, 2) == 0) begin
          m.rready = 1'b0;
          tick();
          chk({tag, "_rhold"}, m.rdata, rexp[i]);
        end
      end
      m.rready = 1'b1;
      t = 0;
      while (!m.rvalid && t < 100) begin tick(); t++; end
      chk({tag, "_rvalid"}, m.rvalid, 1);
      chk({tag, "_rdata"}, m.rdata, rexp[i]);
      chk({tag, "_rid"}, m.rid, id);
      chk({tag, "_rresp"}, m.rresp, exp_resp);
      chk({tag, "_rlast"}, m.rlast, (i == len));
      tick();
    end
    m.rready = 1'b0;
    chk({tag, "_arready_back"}, m.arready, 1);
  endtask

  initial begin
    rstn = 1'b0;
    m.awid = '0; m.awaddr = '0; m.awlen = '0; m.awsize = '0; m.awburst = '0; m.awvalid = 1'b0;
    m.wdata = '0; m.wstrb = '0; m.wlast = 1'b0; m.wvalid = 1'b0; m.bready = 1'b0;
    m.arid = '0; m.araddr = '0; m.arlen = '0; m.arsize = '0; m.arburst = '0; m.arvalid = 1'b0;
    m.rready = 1'b0;
    repeat (3) tick();

    chk("rst_awready", m.awready, 0);
    chk("rst_wready", m.wready, 0);
    chk("rst_bvalid", m.bvalid, 0);
    chk("rst_arready", m.arready, 0);
    chk("rst_rvalid", m.rvalid, 0);
    chk("rst_rlast", m.rlast, 0);
    chk("rst_bresp", m.bresp, 0);
    chk("rst_rresp", m.rresp, 0);
    chk("rst_bid", m.bid, 0);
    chk("rst_rid", m.rid, 0);
    chk("rst_rdata", m.rdata, 0);
    rstn = 1'b1;
    tick();
    chk("post_rst_awready", m.awready, 1);
    chk("post_rst_arready", m.arready, 1);

    // single beat
    wbuf[0] = 64'hA5A5_A5A5_A5A5_A5A5; sbuf[0] = 8'hFF;
    wr_burst(8'd3, 32'h40, 8'd0, 2'b01, 1, 1'b0, 2'b00, "single_wr");
    rexp[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    rd_burst(8'd3, 32'h40, 8'd0, 3'd3, 1'b0, 2'b00, "single_rd");

    // strobe merge on word 2
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
    wr_burst(8'd4, 32'h10, 8'd0, 2'b01, 1, 1'b0, 2'b00, "strb_full");
    wbuf[0] = 64'h0; sbuf[0] = 8'h01;
    wr_burst(8'd5, 32'h10, 8'd0, 2'b01, 1, 1'b0, 2'b00, "strb_byte0");
    rexp[0] = 64'hFFFF_FFFF_FFFF_FF00;
    rd_burst(8'd6, 32'h10, 8'd0, 3'd3, 1'b0, 2'b00, "strb_rd");

    // 16-beat burst at word 32 with stalls on both paths
    for (int unsigned i = 0; i < 16; i++) begin
      wbuf[i] = 64'h0123_4567_0000_0000 + 64'(i); sbuf[i] = 8'hFF;
      rexp[i] = 64'h0123_4567_0000_0000 + 64'(i);
    end
    wr_burst(8'h21, 32'h100, 8'd15, 2'b01, 16, 1'b1, 2'b00, "b16_wr");
    rd_burst(8'h22, 32'h100, 8'd15, 3'd3, 1'b1, 2'b00, "b16_rd");

    // wrap: indices 62, 63, 0, 1
    for (int unsigned i = 0; i < 4; i++) begin
      wbuf[i] = 64'hD0D0_0000_0000_0000 | 64'(i); sbuf[i] = 8'hFF;
      rexp[i] = 64'hD0D0_0000_0000_0000 | 64'(i);
    end
    wr_burst(8'h31, 32'h1F0, 8'd3, 2'b01, 4, 1'b0, 2'b00, "wrap_wr");
    rd_burst(8'h32, 32'h1F0, 8'd3, 3'd3, 1'b0, 2'b00, "wrap_rd");
    rexp[0] = 64'hD0D0_0000_0000_0002;
    rexp[1] = 64'hD0D0_0000_0000_0003;
    rd_burst(8'h33, 32'h0, 8'd1, 3'd3, 1'b0, 2'b00, "wrap_rd0");

    // WRAP burst type: error, word 8 untouched
    wbuf[0] = 64'h1111_1111_1111_1111; sbuf[0] = 8'hFF;
    wr_burst(8'h41, 32'h40, 8'd0, 2'b10, 1, 1'b0, 2'b10, "err_wrap_wr");
    rexp[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    rd_burst(8'h42, 32'h40, 8'd0, 3'd3, 1'b0, 2'b00, "err_wrap_rd");

    // early wlast at beat 1 of len=3
    wbuf[0] = 64'h0000_0000_000B_EEF0; wbuf[1] = 64'h0000_0000_000B_EEF1;
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    wr_burst(8'h51, 32'h180, 8'd3, 2'b01, 2, 1'b0, 2'b10, "err_wlast_wr");
    rexp[0] = 64'h0000_0000_000B_EEF0;
    rd_burst(8'h52, 32'h180, 8'd0, 3'd3, 1'b0, 2'b00, "err_wlast_rd");

    // narrow read size: every beat SLVERR with zero data
    rexp[0] = 64'h0; rexp[1] = 64'h0;
    rd_burst(8'h61, 32'h40, 8'd1, 3'd2, 1'b0, 2'b10, "err_size_rd");

    // overlapping write (word 16) and read (word 32)
    for (int unsigned i = 0; i < 8; i++) begin
      wbuf[i] = 64'h5A5A_0000_0000_0000 + 64'(i); sbuf[i] = 8'hFF;
      rexp[i] = 64'h0123_4567_0000_0000 + 64'(i);
    end
    fork
      wr_burst(8'h71, 32'h80, 8'd7, 2'b01, 8, 1'b1, 2'b00, "conc_wr");
      rd_burst(8'h72, 32'h100, 8'd7, 3'd3, 1'b1, 2'b00, "conc_rd");
    join
    for (int unsigned i = 0; i < 8; i++) rexp[i] = 64'h5A5A_0000_0000_0000 + 64'(i);
    rd_burst(8'h73, 32'h80, 8'd7, 3'd3, 1'b0, 2'b00, "conc_chk");

    // reset asserted mid-burst on both paths
    m.awid = 8'h81; m.awaddr = 32'h80; m.awlen = 8'd7; m.awsize = 3'd3; m.awburst = 2'b01;
    m.arid = 8'h82; m.araddr = 32'h100; m.arlen = 8'd7; m.arsize = 3'd3; m.arburst = 2'b01;
    m.awvalid = 1'b1; m.arvalid = 1'b1;
    tick();
    m.awvalid = 1'b0; m.arvalid = 1'b0;
    chk("abort_wready_pre", m.wready, 1);
    chk("abort_rvalid_pre", m.rvalid, 1);
    m.wvalid = 1'b1; m.wdata = 64'hDEAD; m.wstrb = 8'hFF; m.wlast = 1'b0;
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("abort_awready", m.awready, 0);
    chk("abort_wready", m.wready, 0);
    chk("abort_bvalid", m.bvalid, 0);
    chk("abort_arready", m.arready, 0);
    chk("abort_rvalid", m.rvalid, 0);
    chk("abort_rdata", m.rdata, 0);
    m.wvalid = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("rel_awready", m.awready, 1);
    chk("rel_arready", m.arready, 1);
    chk("rel_bvalid", m.bvalid, 0);
    chk("rel_rvalid", m.rvalid, 0);
    wbuf[0] = 64'h7777_7777_7777_7777; sbuf[0] = 8'hFF;
    wr_burst(8'h91, 32'h28, 8'd0, 2'b01, 1, 1'b0, 2'b00, "rel_wr");
    rexp[0] = 64'h7777_7777_7777_7777;
    rd_burst(8'h92, 32'h28, 8'd0, 3'd3, 1'b0, 2'b00, "rel_rd");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
